// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execute-stage FSM state encoding.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath: one partial product per run cycle.
// Latency: WIDTH run cycles, or fewer when ALU_MUL_EARLY_TERM_EN is defined.
// Backpressure: none; the owning FSM only starts it when the output slot is free.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // Load operands on start, otherwise accumulate one shifted partial product per run cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (run) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Flag the iteration that finishes the product so the FSM can leave MUL on this edge.
`ifdef ALU_MUL_EARLY_TERM_EN
  // Remaining multiplier bits all zero means the accumulator is already final.
  always_comb last = run && ((cnt == LAST_CNT) || ((mplier >> 1) == '0));
`else
  always_comb last = run && (cnt == LAST_CNT);
`endif

  assign product = acc;

endmodule

// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU: add/sub/slt/unknown in one cycle, mul via alu_mul_iter (ALU_MUL_EARLY_TERM_EN optional).
// Latency: single-cycle ops register on the accept edge; mul result WIDTH+1 edges after accept.
// Backpressure: in_ready drops while a mul is in flight or an unaccepted result sits in the output register.
module alu_multicycle_exec #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              busy
);

  import alu_pkg::*;

  alu_state_t       state, state_nxt;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_run;
  logic             mul_last;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] single_res;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (alu_ctrl == CTRL_W'(ALU_MUL));
  assign mul_start = accept && is_mul;
  assign mul_run   = (state == MUL);
  assign busy      = (state == MUL);

  // Single-cycle operations; anything not recognised falls back to add like the decoder.
  always_comb begin
    single_res = src_a + src_b;
    case (alu_ctrl)
      CTRL_W'(ALU_SUB): single_res = src_a - src_b;
      CTRL_W'(ALU_SLT): single_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default:          single_res = src_a + src_b;
    endcase
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .run     (mul_run),
    .a       (src_a),
    .b       (src_b),
    .last    (mul_last),
    .product (mul_prod)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: only a mul leaves IDLE; DONE is a one-cycle hop that publishes the product.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MUL;
      MUL:     if (mul_last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: load a mul product or single-cycle result, otherwise hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (state == DONE) begin
      out_valid <= 1'b1;
      result    <= mul_prod;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= single_res;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle_exec.sv
module tb_alu_multicycle_exec;

  localparam int W = 32;
`ifdef ALU_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    alu_ctrl = 4'd0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  alu_multicycle_exec #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Reference: the architectural result of each operation in plain arithmetic.
  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'b0001: return a - b;
      4'b0010: return a * b;
      4'b0011: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  // Edges after the accept edge until out_valid shows: 0 for single-cycle ops,
  // iterations+1 for mul (iterations = WIDTH, or just enough to exhaust the multiplier).
  function automatic int exp_edges(input logic [3:0] c, input logic [W-1:0] b);
    int iters;
    if (c != 4'b0010) return 0;
    iters = 1;
    while (iters < W && (!EARLY || (b >> iters) != 0)) iters++;
    return iters + 1;
  endfunction

  // Issue one request with out_ready high, wait for its result, verify value, timing and stall signals.
  task automatic do_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input bit poke);
    int n;
    int waitc;
    int bad_busy;
    int bad_rdy;
    int en;
    en = exp_edges(c, b);
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    src_a    = $urandom;
    src_b    = $urandom;
    n = 0;
    bad_busy = 0;
    bad_rdy  = 0;
    while (!out_valid && n < 200) begin
      if (busy !== (n < en - 1)) bad_busy++;
      if (in_ready !== 1'b0) bad_rdy++;
      if (poke && n == 2) begin
        in_valid = 1'b1;
        alu_ctrl = 4'b0000;
      end
      if (poke && n == 6) in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, n, en);
    check({name, "_result"}, result, exp);
    if (c == 4'b0010) begin
      check({name, "_busy_window"}, bad_busy, 0);
      check({name, "_stall_window"}, bad_rdy, 0);
    end
    @(negedge clk);
    check({name, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[2]  = '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4]  = '{4'b1010, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005};
    vecs[5]  = '{4'b0010, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF};
    vecs[6]  = '{4'b0010, 32'h0000_0007, 32'h0000_0003, 32'h0000_0015};
    vecs[7]  = '{4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[8]  = '{4'b0010, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{4'b0011, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
    vecs[10] = '{4'b1111, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[11] = '{4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};

    // Reset values, during and after reset.
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_result", result, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops with out_ready held high.
    in_valid = 1'b1; alu_ctrl = 4'b0000; src_a = 32'hFFFF_FFFF; src_b = 32'd1;
    @(negedge clk);
    check("b2b_add_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_add_result", result, 32'h0000_0000);
    check("b2b_ready", {31'd0, in_ready}, 32'd1);
    alu_ctrl = 4'b0001; src_a = 32'd5; src_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_sub_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_sub_result", result, 32'hFFFF_FFFE);
    @(negedge clk);
    check("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      check($sformatf("vec%0d_model", i), model(vecs[i].ctrl, vecs[i].a, vecs[i].b), vecs[i].exp);
      do_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
    end

    // Mul with a second request arriving while busy; it must be ignored.
    do_op("mul_poke", 4'b0010, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b1);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b0000; src_a = 32'd100; src_b = 32'd23;
    @(negedge clk);
    in_valid = 1'b0; src_a = 32'd0; src_b = 32'd0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_valid%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold_result%0d", k), result, 32'd123);
      check($sformatf("bp_hold_ready%0d", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("bp_consumed", {31'd0, out_valid}, 32'd0);

    // Reset asserted mid-mul aborts without emitting a result.
    in_valid = 1'b1; alu_ctrl = 4'b0010; src_a = 32'hDEAD_BEEF; src_b = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_mul_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 45; k++) begin
        @(negedge clk);
        if (out_valid || busy) seen++;
      end
      check("mid_rst_no_result", seen, 0);
    end

    // Randomized ops against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [3:0] c;
      logic [W-1:0] a;
      logic [W-1:0] b;
      c = 4'($urandom_range(0, 15));
      if (r % 4 == 0) c = 4'b0010;
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 255));
      do_op($sformatf("rnd%0d", r), c, a, b, model(c, a, b), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
